riscv_trace_collector: RTL and testbench
========================================

# riscv_trace_collector

In-order retirement capture buffer for the simulation/debug tracer. It sits directly downstream of the ID/EX issue point:
- records each issued instruction's PC, encoding and destination-register write;
- classifies the encoding against the tracer instruction masks;
- holds loads until their data returns;
- presents completed records in program order on a valid/ready port to the trace printer.

## Interface
Parameters:
- DEPTH, 4: record FIFO entries; power of two, 2..16.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  instruction issued this cycle.
- issue_pc_i  in  32  PC of the issued instruction.
- issue_instr_i  in  32  uncompressed encoding.
- issue_rd_we_i  in  1  instruction writes a register.
- issue_rd_addr_i  in  5  destination register.
- issue_rd_wdata_i  in  32  ALU/CSR result; ignored for loads.
- load_rvalid_i  in  1  load data returned (in order).
- load_rdata_i  in  32  returned load data.
- trace_valid_o  out  1  head record complete.
- trace_ready_i  in  1  printer accepts head.
- trace_pc_o  out  32  head PC.
- trace_instr_o  out  32  head encoding.
- trace_class_o  out  4  head class (trace_class_e).
- trace_rd_we_o  out  1  head writes a register.
- trace_rd_addr_o  out  5  head destination register.
- trace_rd_wdata_o  out  32  head write data.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_cnt_o  out  DROP_W  dropped records, saturating.
- proto_err_o  out  1  sticky: load_rvalid_i with no pending load.

## Operation
Classification:
- Priority casez of issue_instr_i against the package masks.
- Order: MULDIV before ALU_REG. PULP before ALU_REG. FENCE, SYSTEM, CSR, LOAD, STORE, BRANCH, JUMP (JAL/JALR), UPPER (LUI/AUIPC), ALU_IMM.
- Anything else is UNKNOWN. UNKNOWN is still recorded.

Capture:
- A record is written at the tail on issue_valid_i.
- done=1 immediately, except class LOAD with issue_rd_we_i=1, which gets done=0.

Load completion:
- load_rvalid_i sets done=1 on the oldest entry with done=0.
- It also writes load_rdata_i into that entry's wdata.
- A load never completes in its own capture cycle; rvalid applies only to entries present before the edge.
- rvalid with no done=0 entry: ignored, proto_err_o set.

Output:
- trace_valid_o = FIFO not empty AND head.done.
- Pop on trace_valid_o && trace_ready_i.
- Records never reorder. A pending load blocks all younger completed records.

Full:
- Capture is accepted if count<DEPTH, or if the head pops in the same cycle.
- Otherwise the record is discarded, overflow_o is set, and drop_cnt_o increments, saturating at all-ones.
- A dropped load still consumes its later rvalid against the next pending load. This desync is accepted and is flagged only via overflow_o.

Reset:
- Asynchronous clear of pointers, count, done flags, overflow_o, proto_err_o and drop_cnt_o.
- In-flight records are lost.

## Timing
- All outputs are registered from FIFO state. Reset values: trace_valid_o=0, all data outputs 0, flags/counters 0.
- Non-load latency: issue at edge N → trace_valid_o high in cycle N+1.
- Load latency: rvalid at edge M → trace_valid_o high in cycle M+1, provided that load is at the head.
- Same cycle capture + pop + rvalid: all three take effect; count changes by (capture − pop).
- Same cycle rvalid and pop of the entry being completed: impossible, because done=0 blocks the pop.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Throughput: one record per cycle sustained when trace_ready_i=1.

## Structure
- Shared package riscv_tracer_defines (extended):
  - trace_class_e (4-bit enum: ALU_REG, ALU_IMM, UPPER, BRANCH, JUMP, LOAD, STORE, CSR, SYSTEM, FENCE, MULDIV, PULP, UNKNOWN);
  - trace_rec_t struct {pc, instr, cls, rd_we, rd_addr, wdata, done}.
- Sub-module riscv_trace_classify: combinational instr → trace_class_e. Reused by the printer.
- The collector holds the FIFO array, pointers, pending-load search (priority from head) and counters.

## Test plan
- ADDI 0x00500093 at PC 0x80 with wdata 5 → next cycle valid, class ALU_IMM, rd 1, wdata 5; popped with ready=1.
- LW 0x0000A103, then ADD, issued back to back; rvalid 0xDEADBEEF three cycles later → nothing valid until the cycle after rvalid. LW then emits (wdata 0xDEADBEEF), then ADD on the next cycle.
- DEPTH=4, ready=0, 6 issues → 4 stored, drop_cnt_o=2, overflow_o=1. Then ready=1 → 4 records out in order.
- Full FIFO, ready=1, issue in the same cycle → accepted, no drop, count stays 4.
- load_rvalid_i with an empty FIFO → proto_err_o=1, no output. rst_n low mid-stream → all outputs 0 asynchronously.
- Encodings MUL 0x02208033, p.avg (funct7 0000010), CSRRW, FENCE, 0xFFFFFFFF → classes MULDIV, PULP, CSR, FENCE, UNKNOWN.

Source files
------------

// File: rtl/riscv_trace_collector_pkg.sv
// Shared tracer definitions: instruction classes, record layout and the
// encoding masks used by the classifier.
package riscv_tracer_defines;

    typedef enum logic [3:0] {
        ALU_REG, ALU_IMM, UPPER, BRANCH, JUMP, LOAD, STORE,
        CSR, SYSTEM, FENCE, MULDIV, PULP, UNKNOWN
    } trace_class_e;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  instr;
        trace_class_e cls;
        logic         rd_we;
        logic [4:0]   rd_addr;
        logic [31:0]  wdata;
        logic         done;
    } trace_rec_t;

    // Masks are matched in priority order; earlier masks shadow later ones.
    localparam logic [31:0] MASK_MULDIV  = 32'b0000001_?????_?????_???_?????_0110011;
    localparam logic [31:0] MASK_PULP    = 32'b0000010_?????_?????_???_?????_0110011;
    localparam logic [31:0] MASK_ALU_REG = 32'b???????_?????_?????_???_?????_0110011;
    localparam logic [31:0] MASK_FENCE   = 32'b???????_?????_?????_???_?????_0001111;
    localparam logic [31:0] MASK_SYSTEM  = 32'b???????_?????_?????_000_?????_1110011;
    localparam logic [31:0] MASK_CSR     = 32'b???????_?????_?????_???_?????_1110011;
    localparam logic [31:0] MASK_LOAD    = 32'b???????_?????_?????_???_?????_0000011;
    localparam logic [31:0] MASK_STORE   = 32'b???????_?????_?????_???_?????_0100011;
    localparam logic [31:0] MASK_BRANCH  = 32'b???????_?????_?????_???_?????_1100011;
    localparam logic [31:0] MASK_JAL     = 32'b???????_?????_?????_???_?????_1101111;
    localparam logic [31:0] MASK_JALR    = 32'b???????_?????_?????_???_?????_1100111;
    localparam logic [31:0] MASK_LUI     = 32'b???????_?????_?????_???_?????_0110111;
    localparam logic [31:0] MASK_AUIPC   = 32'b???????_?????_?????_???_?????_0010111;
    localparam logic [31:0] MASK_ALU_IMM = 32'b???????_?????_?????_???_?????_0010011;

endpackage

// File: rtl/riscv_trace_classify.sv
// Combinational instruction classifier shared by the collector and the printer.
module riscv_trace_classify
    import riscv_tracer_defines::*;
(
    input  logic [31:0]  i_instr,
    output trace_class_e o_class
);

    always_comb begin
        o_class = UNKNOWN;
        casez (i_instr)
            MASK_MULDIV:  o_class = MULDIV;
            MASK_PULP:    o_class = PULP;
            MASK_ALU_REG: o_class = ALU_REG;
            MASK_FENCE:   o_class = FENCE;
            MASK_SYSTEM:  o_class = SYSTEM;
            MASK_CSR:     o_class = CSR;
            MASK_LOAD:    o_class = LOAD;
            MASK_STORE:   o_class = STORE;
            MASK_BRANCH:  o_class = BRANCH;
            MASK_JAL:     o_class = JUMP;
            MASK_JALR:    o_class = JUMP;
            MASK_LUI:     o_class = UPPER;
            MASK_AUIPC:   o_class = UPPER;
            MASK_ALU_IMM: o_class = ALU_IMM;
            default:      o_class = UNKNOWN;
        endcase
    end

endmodule

// File: rtl/riscv_trace_collector.sv
// In-order retirement capture FIFO: records issued instructions, completes
// loads with returned data and emits finished records in program order.
module riscv_trace_collector
    import riscv_tracer_defines::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid_i,
    input  logic [31:0]       issue_pc_i,
    input  logic [31:0]       issue_instr_i,
    input  logic              issue_rd_we_i,
    input  logic [4:0]        issue_rd_addr_i,
    input  logic [31:0]       issue_rd_wdata_i,
    input  logic              load_rvalid_i,
    input  logic [31:0]       load_rdata_i,
    output logic              trace_valid_o,
    input  logic              trace_ready_i,
    output logic [31:0]       trace_pc_o,
    output logic [31:0]       trace_instr_o,
    output trace_class_e      trace_class_o,
    output logic              trace_rd_we_o,
    output logic [4:0]        trace_rd_addr_o,
    output logic [31:0]       trace_rd_wdata_o,
    output logic              overflow_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              proto_err_o
);

    localparam int AW = $clog2(DEPTH);

    trace_rec_t        r_mem [DEPTH];
    logic [DEPTH-1:0]  r_done;
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic              r_proto_err;
    logic [DROP_W-1:0] r_drop_cnt;

    trace_class_e      w_cls;
    trace_rec_t        w_new;
    trace_rec_t        w_head;
    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic              w_ld_hit;
    logic              w_ld_done;
    logic [AW-1:0]     w_ld_idx;

    riscv_trace_classify u_classify (
        .i_instr (issue_instr_i),
        .o_class (w_cls)
    );

    // Scan youngest to oldest so the last match left standing is the oldest pending load.
    always_comb begin
        w_ld_hit = 1'b0;
        w_ld_idx = r_head;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (((AW+1)'(i) < r_count) && !r_done[r_head + AW'(i)]) begin
                w_ld_hit = 1'b1;
                w_ld_idx = r_head + AW'(i);
            end
        end
    end

    always_comb begin
        w_new.pc      = issue_pc_i;
        w_new.instr   = issue_instr_i;
        w_new.cls     = w_cls;
        w_new.rd_we   = issue_rd_we_i;
        w_new.rd_addr = issue_rd_addr_i;
        w_new.wdata   = (w_cls == LOAD) ? 32'd0 : issue_rd_wdata_i;
        w_new.done    = !((w_cls == LOAD) && issue_rd_we_i);
    end

    always_comb begin
        w_head      = r_mem[r_head];
        w_head.done = r_done[r_head];
    end

    assign trace_valid_o = (r_count != '0) && w_head.done;
    assign w_pop         = trace_valid_o && trace_ready_i;
    assign w_accept      = issue_valid_i && ((r_count < (AW+1)'(DEPTH)) || w_pop);
    assign w_drop        = issue_valid_i && !w_accept;
    assign w_ld_done     = load_rvalid_i && w_ld_hit;

    // Record payload carries no reset; occupancy is governed by r_count and r_done.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_tail] <= w_new;
        end
        if (w_ld_done) begin
            r_mem[w_ld_idx].wdata <= load_rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_done[r_tail] <= w_new.done;
                r_tail         <= r_tail + AW'(1);
            end
            if (w_ld_done) begin
                r_done[w_ld_idx] <= 1'b1;
            end
            if (load_rvalid_i && !w_ld_hit) begin
                r_proto_err <= 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (!(&r_drop_cnt)) begin
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
                end
            end
        end
    end

    assign trace_pc_o       = trace_valid_o ? w_head.pc      : 32'd0;
    assign trace_instr_o    = trace_valid_o ? w_head.instr   : 32'd0;
    assign trace_class_o    = trace_valid_o ? w_head.cls     : ALU_REG;
    assign trace_rd_we_o    = trace_valid_o ? w_head.rd_we   : 1'b0;
    assign trace_rd_addr_o  = trace_valid_o ? w_head.rd_addr : 5'd0;
    assign trace_rd_wdata_o = trace_valid_o ? w_head.wdata   : 32'd0;
    assign overflow_o       = r_overflow;
    assign drop_cnt_o       = r_drop_cnt;
    assign proto_err_o      = r_proto_err;

endmodule

// File: tb/tb_riscv_trace_collector.sv
// Self-checking bench for riscv_trace_collector: directed sequences, a
// classification table and randomized traffic against a queue-based model.
module tb_riscv_trace_collector;
    import riscv_tracer_defines::*;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic [31:0]       issue_pc_i = '0;
    logic [31:0]       issue_instr_i = '0;
    logic              issue_rd_we_i = 1'b0;
    logic [4:0]        issue_rd_addr_i = '0;
    logic [31:0]       issue_rd_wdata_i = '0;
    logic              load_rvalid_i = 1'b0;
    logic [31:0]       load_rdata_i = '0;
    logic              trace_ready_i = 1'b0;
    logic              trace_valid_o;
    logic [31:0]       trace_pc_o;
    logic [31:0]       trace_instr_o;
    trace_class_e      trace_class_o;
    logic              trace_rd_we_o;
    logic [4:0]        trace_rd_addr_o;
    logic [31:0]       trace_rd_wdata_o;
    logic              overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              proto_err_o;

    riscv_trace_collector #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .issue_valid_i    (issue_valid_i),
        .issue_pc_i       (issue_pc_i),
        .issue_instr_i    (issue_instr_i),
        .issue_rd_we_i    (issue_rd_we_i),
        .issue_rd_addr_i  (issue_rd_addr_i),
        .issue_rd_wdata_i (issue_rd_wdata_i),
        .load_rvalid_i    (load_rvalid_i),
        .load_rdata_i     (load_rdata_i),
        .trace_valid_o    (trace_valid_o),
        .trace_ready_i    (trace_ready_i),
        .trace_pc_o       (trace_pc_o),
        .trace_instr_o    (trace_instr_o),
        .trace_class_o    (trace_class_o),
        .trace_rd_we_o    (trace_rd_we_o),
        .trace_rd_addr_o  (trace_rd_addr_o),
        .trace_rd_wdata_o (trace_rd_wdata_o),
        .overflow_o       (overflow_o),
        .drop_cnt_o       (drop_cnt_o),
        .proto_err_o      (proto_err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0]  pc;
        logic [31:0]  instr;
        trace_class_e cls;
        logic         we;
        logic [4:0]   rd;
        logic [31:0]  wdata;
        logic         done;
    } mrec_t;

    mrec_t mq[$];
    logic  m_ovf;
    logic  m_perr;
    int    m_drop;

    typedef struct {
        logic [31:0]  instr;
        logic         we;
        trace_class_e cls;
    } cls_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Decode by opcode/funct fields straight from the ISA tables.
    function automatic trace_class_e model_cls(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (op)
            7'h33: model_cls = (f7 == 7'd1) ? MULDIV : (f7 == 7'd2) ? PULP : ALU_REG;
            7'h0F: model_cls = FENCE;
            7'h73: model_cls = (f3 == 3'd0) ? SYSTEM : CSR;
            7'h03: model_cls = LOAD;
            7'h23: model_cls = STORE;
            7'h63: model_cls = BRANCH;
            7'h6F, 7'h67: model_cls = JUMP;
            7'h37, 7'h17: model_cls = UPPER;
            7'h13: model_cls = ALU_IMM;
            default: model_cls = UNKNOWN;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        m_drop = 0;
    endtask

    // Applies one clock of the buffer rules using the inputs present before the edge.
    task automatic model_step();
        bit    pop;
        bit    acc;
        int    tgt;
        mrec_t r;
        pop = trace_ready_i && (mq.size() > 0) && mq[0].done;
        tgt = -1;
        foreach (mq[k]) if (tgt < 0 && !mq[k].done) tgt = k;
        acc = issue_valid_i && ((mq.size() < DEPTH) || pop);
        if (load_rvalid_i) begin
            if (tgt >= 0) begin
                r = mq[tgt];
                r.done  = 1'b1;
                r.wdata = load_rdata_i;
                mq[tgt] = r;
            end else begin
                m_perr = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (acc) begin
            r.pc    = issue_pc_i;
            r.instr = issue_instr_i;
            r.cls   = model_cls(issue_instr_i);
            r.we    = issue_rd_we_i;
            r.rd    = issue_rd_addr_i;
            r.wdata = (r.cls == LOAD) ? 32'd0 : issue_rd_wdata_i;
            r.done  = !((r.cls == LOAD) && issue_rd_we_i);
            mq.push_back(r);
        end else if (issue_valid_i) begin
            m_ovf = 1'b1;
            if (m_drop < (2**DROP_W) - 1) m_drop++;
        end
    endtask

    task automatic check_all();
        logic ev;
        ev = (mq.size() > 0) && mq[0].done;
        chk("valid", trace_valid_o, ev);
        if (ev) begin
            chk("pc",    trace_pc_o,       mq[0].pc);
            chk("instr", trace_instr_o,    mq[0].instr);
            chk("class", trace_class_o,    mq[0].cls);
            chk("rd_we", trace_rd_we_o,    mq[0].we);
            chk("rd",    trace_rd_addr_o,  mq[0].rd);
            chk("wdata", trace_rd_wdata_o, mq[0].wdata);
        end
        chk("overflow",  overflow_o,  m_ovf);
        chk("drop_cnt",  drop_cnt_o,  m_drop);
        chk("proto_err", proto_err_o, m_perr);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_issue(input logic [31:0] pc, input logic [31:0] ins, input logic we,
                             input logic [4:0] rd, input logic [31:0] wd);
        issue_valid_i    = 1'b1;
        issue_pc_i       = pc;
        issue_instr_i    = ins;
        issue_rd_we_i    = we;
        issue_rd_addr_i  = rd;
        issue_rd_wdata_i = wd;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        load_rvalid_i = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        trace_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_ADD  = 32'h002081B3;

    cls_vec_t cv[15];

    initial begin
        cv[0]  = '{32'h02208033, 1'b1, MULDIV};
        cv[1]  = '{32'h04208033, 1'b1, PULP};
        cv[2]  = '{32'h34011073, 1'b0, CSR};
        cv[3]  = '{32'h0FF0000F, 1'b0, FENCE};
        cv[4]  = '{32'hFFFFFFFF, 1'b0, UNKNOWN};
        cv[5]  = '{I_ADD,        1'b1, ALU_REG};
        cv[6]  = '{I_ADDI,       1'b1, ALU_IMM};
        cv[7]  = '{32'h000012B7, 1'b1, UPPER};
        cv[8]  = '{32'h00000297, 1'b1, UPPER};
        cv[9]  = '{32'h0000006F, 1'b1, JUMP};
        cv[10] = '{32'h00008067, 1'b0, JUMP};
        cv[11] = '{32'h00000063, 1'b0, BRANCH};
        cv[12] = '{32'h0020A023, 1'b0, STORE};
        cv[13] = '{32'h00000073, 1'b0, SYSTEM};
        cv[14] = '{I_LW,         1'b0, LOAD};

        model_clear();
        do_reset();

        chk("rst_valid", trace_valid_o, 1'b0);
        chk("rst_pc", trace_pc_o, 32'd0);
        chk("rst_wdata", trace_rd_wdata_o, 32'd0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_drop", drop_cnt_o, 32'd0);
        chk("rst_proto", proto_err_o, 1'b0);

        // Single ADDI, popped immediately.
        trace_ready_i = 1'b1;
        set_issue(32'h80, I_ADDI, 1'b1, 5'd1, 32'd5);
        cyc();
        idle();
        chk("addi_valid", trace_valid_o, 1'b1);
        chk("addi_pc", trace_pc_o, 32'h80);
        chk("addi_class", trace_class_o, ALU_IMM);
        chk("addi_rd", trace_rd_addr_o, 32'd1);
        chk("addi_wdata", trace_rd_wdata_o, 32'd5);
        cyc();
        chk("addi_popped", trace_valid_o, 1'b0);

        // Pending load blocks the younger ADD until its data returns.
        set_issue(32'h100, I_LW, 1'b1, 5'd2, 32'h1111);
        cyc();
        chk("lw_wait0", trace_valid_o, 1'b0);
        set_issue(32'h104, I_ADD, 1'b1, 5'd3, 32'd7);
        cyc();
        chk("lw_wait1", trace_valid_o, 1'b0);
        idle();
        cyc();
        chk("lw_wait2", trace_valid_o, 1'b0);
        load_rvalid_i = 1'b1;
        load_rdata_i  = 32'hDEADBEEF;
        cyc();
        idle();
        chk("lw_valid", trace_valid_o, 1'b1);
        chk("lw_pc", trace_pc_o, 32'h100);
        chk("lw_wdata", trace_rd_wdata_o, 32'hDEADBEEF);
        cyc();
        chk("add_pc", trace_pc_o, 32'h104);
        chk("add_wdata", trace_rd_wdata_o, 32'd7);
        cyc();
        chk("lw_drained", trace_valid_o, 1'b0);

        // Overflow with the printer stalled, then in-order drain.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_issue(32'h200 + 32'(4 * k), I_ADDI, 1'b1, 5'd1, 32'(k));
            cyc();
        end
        idle();
        chk("ovf_drop", drop_cnt_o, 32'd2);
        chk("ovf_flag", overflow_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_out_valid", trace_valid_o, 1'b1);
            chk("ovf_out_pc", trace_pc_o, 32'h200 + 32'(4 * k));
            trace_ready_i = 1'b1;
            cyc();
        end
        chk("ovf_empty", trace_valid_o, 1'b0);

        // Full FIFO accepts a capture when the head pops in the same cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_issue(32'h300 + 32'(4 * k), I_ADDI, 1'b1, 5'd4, 32'(k));
            cyc();
        end
        trace_ready_i = 1'b1;
        set_issue(32'h310, I_ADDI, 1'b1, 5'd4, 32'd4);
        cyc();
        idle();
        chk("fullpop_drop", drop_cnt_o, 32'd0);
        chk("fullpop_ovf", overflow_o, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            chk("fullpop_valid", trace_valid_o, 1'b1);
            chk("fullpop_pc", trace_pc_o, 32'h300 + 32'(4 * k));
            cyc();
        end
        chk("fullpop_empty", trace_valid_o, 1'b0);

        // Drop counter saturates.
        do_reset();
        for (int k = 0; k < 24; k++) begin
            set_issue(32'h500 + 32'(4 * k), I_ADDI, 1'b1, 5'd1, 32'd0);
            cyc();
        end
        idle();
        chk("drop_sat", drop_cnt_o, 32'(2**DROP_W - 1));

        // Load data with nothing pending.
        do_reset();
        load_rvalid_i = 1'b1;
        load_rdata_i  = 32'h12345678;
        cyc();
        idle();
        chk("proto_set", proto_err_o, 1'b1);
        chk("proto_novalid", trace_valid_o, 1'b0);
        cyc();
        chk("proto_sticky", proto_err_o, 1'b1);

        // Classification table.
        do_reset();
        trace_ready_i = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_issue(32'h400 + 32'(4 * i), cv[i].instr, cv[i].we, 5'd5, 32'(i));
            cyc();
            chk("tbl_valid", trace_valid_o, 1'b1);
            chk("tbl_class", trace_class_o, cv[i].cls);
        end
        idle();
        cyc();

        // Asynchronous reset in the middle of a cycle.
        trace_ready_i = 1'b0;
        load_rvalid_i = 1'b1;
        cyc();
        set_issue(32'h600, I_ADDI, 1'b1, 5'd6, 32'd9);
        cyc();
        set_issue(32'h604, I_ADDI, 1'b1, 5'd6, 32'd9);
        cyc();
        idle();
        chk("pre_arst_valid", trace_valid_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", trace_valid_o, 1'b0);
        chk("arst_pc", trace_pc_o, 32'd0);
        chk("arst_proto", proto_err_o, 1'b0);
        chk("arst_ovf", overflow_o, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [4:0]  rd;
            logic [31:0] ins;
            bit          pend;
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: ins = {12'($urandom), 5'($urandom), 3'b010, rd, 7'b0000011};
                1: ins = {7'd0, 5'($urandom), 5'($urandom), 3'b000, rd, 7'b0110011};
                2: ins = {12'($urandom), 5'($urandom), 3'b000, rd, 7'b0010011};
                3: ins = {7'd1, 5'($urandom), 5'($urandom), 3'b000, rd, 7'b0110011};
                4: ins = $urandom;
                default: ins = {7'($urandom), 5'($urandom), 5'($urandom), 3'b010, 5'($urandom), 7'b0100011};
            endcase
            issue_valid_i    = ($urandom_range(0, 99) < 60);
            issue_pc_i       = $urandom;
            issue_instr_i    = ins;
            issue_rd_we_i    = ($urandom_range(0, 99) < 80);
            issue_rd_addr_i  = rd;
            issue_rd_wdata_i = $urandom;
            pend = 1'b0;
            foreach (mq[k]) if (!mq[k].done) pend = 1'b1;
            load_rvalid_i = (pend && $urandom_range(0, 99) < 40) || ($urandom_range(0, 99) < 2);
            load_rdata_i  = $urandom;
            trace_ready_i = ($urandom_range(0, 99) < (((c % 400) < 100) ? 10 : 80));
            cyc();
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
